// File: rtl/div_rep_sub_if.sv
// Handshake/operand bus for the repeated-subtraction divider.
// The master drives start/data_in and the slave (divider) returns the results.
interface div_rep_sub_if;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    modport master (
        output start, data_in,
        input  quotient, remainder, done, busy, div_by_zero
    );

    modport slave (
        input  start, data_in,
        output quotient, remainder, done, busy, div_by_zero
    );
endinterface

// File: rtl/div_rep_sub.sv
// Unsigned 16-bit divider by repeated subtraction: the FSM loads the dividend,
// then the divisor, from one shared bus and subtracts until R < B.
module div_rep_sub (
    input  logic         i_clk,
    input  logic         i_rst,
    div_rep_sub_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_r;
    logic [15:0] r_b;
    logic [15:0] r_q;
    logic        r_done;
    logic        r_busy;
    logic        r_dbz;

    logic [15:0] w_diff;
    logic        w_r_ge_b;
    logic        w_b_zero;

    assign w_diff   = r_r - r_b;
    assign w_r_ge_b = (r_r >= r_b);
    assign w_b_zero = (r_b == 16'd0);

    // Status flags are registered alongside the state so they never depend on inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_r     <= 16'd0;
            r_b     <= 16'd0;
            r_q     <= 16'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LDA;
                        r_busy  <= 1'b1;
                    end
                end
                S_LDA: begin
                    r_r     <= bus.data_in;
                    r_state <= S_LDB;
                end
                S_LDB: begin
                    r_b     <= bus.data_in;
                    r_q     <= 16'd0;
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    if (w_b_zero) begin
                        r_state <= S_DONE;
                        r_dbz   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_r_ge_b) begin
                        r_r <= w_diff;
                        r_q <= r_q + 16'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_LDA;
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dbz   <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = r_q;
    assign bus.remainder   = r_r;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_rep_sub.sv
// Directed plus randomized checks of div_rep_sub against plain integer division.
module tb_div_rep_sub;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    div_rep_sub_if bus ();

    div_rep_sub dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE or DONE.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input bit hold_start, input bit pulse_start);
        int unsigned exp_q, exp_r, exp_lat, cnt, bad;
        logic exp_dbz;
        exp_dbz = (b == 16'd0);
        exp_q   = exp_dbz ? 0 : a / b;
        exp_r   = exp_dbz ? a : a % b;
        exp_lat = exp_q + 4;

        bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        bus.data_in = a;
        check("busy_lda", bus.busy, 1'b1);
        check("dbz_clr_lda", bus.div_by_zero, 1'b0);
        @(posedge clk); #1;
        bus.data_in = b;
        @(posedge clk); #1;
        bus.data_in = 16'($urandom);
        cnt = 3;
        bad = 0;
        while (!bus.done && cnt < 70000) begin
            if (!bus.busy || bus.div_by_zero) bad++;
            if (pulse_start) bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cnt++;
        end
        bus.start = 1'b0;
        check("latency", cnt, exp_lat);
        check("done", bus.done, 1'b1);
        check("busy_done", bus.busy, 1'b0);
        check("quotient", bus.quotient, exp_q);
        check("remainder", bus.remainder, exp_r);
        check("div_by_zero", bus.div_by_zero, exp_dbz);
        check("busy_flags_during_op", bad, 0);
        @(posedge clk); #1;
        check("done_hold", bus.done, 1'b1);
        check("quotient_hold", bus.quotient, exp_q);
        check("remainder_hold", bus.remainder, exp_r);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", bus.done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        check("rst_q", bus.quotient, 16'd0);
        check("rst_r", bus.remainder, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_start", bus.busy, 1'b0);

        do_div(16'd17, 16'd5, 1'b0, 1'b0);
        do_div(16'd9,  16'd0, 1'b0, 1'b0);
        do_div(16'd0,  16'd7, 1'b0, 1'b0);
        do_div(16'd5,  16'd5, 1'b0, 1'b0);
        do_div(16'd17, 16'd5, 1'b0, 1'b0);
        do_div(16'd100, 16'd7, 1'b1, 1'b1);

        // Reset in the middle of a subtraction run.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = 16'd17;
        @(posedge clk); #1;
        bus.data_in = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        check("mid_q", bus.quotient, 16'd2);
        check("mid_r", bus.remainder, 16'd7);
        rst = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("midrst_done", bus.done, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_dbz", bus.div_by_zero, 1'b0);
        check("midrst_q", bus.quotient, 16'd0);
        check("midrst_r", bus.remainder, 16'd0);
        do_div(16'd20, 16'd6, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_div(16'($urandom_range(0, 511)), 16'($urandom_range(0, 40)),
                   1'($urandom_range(0, 1)), 1'b1);
        end

        do_div(16'hFFFF, 16'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
